// File: rtl/inst_fetch_queue_if.sv
// Bundle between the PC stage / decode / program loader and the instruction fetch queue.
// The queue side uses the slave modport; the surrounding pipeline drives through master.
interface inst_fetch_queue_if #(
  parameter int A = 4,
  parameter int W = 9
);
  logic [A-1:0] inst_addr_in;
  logic         halt_in;
  logic         prog_we;
  logic [A-1:0] prog_addr;
  logic [W-1:0] prog_data;
  logic         flush;
  logic         id_ready;
  logic [W-1:0] inst_out;
  logic [A-1:0] pc_out;
  logic         valid_out;
  logic         fetch_stall;
  logic         halt_out;

  modport master (
    output inst_addr_in, halt_in, prog_we, prog_addr, prog_data, flush, id_ready,
    input  inst_out, pc_out, valid_out, fetch_stall, halt_out
  );

  modport slave (
    input  inst_addr_in, halt_in, prog_we, prog_addr, prog_data, flush, id_ready,
    output inst_out, pc_out, valid_out, fetch_stall, halt_out
  );
endinterface

// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: synchronous-read instruction memory, one F1 read register and a
// small {pc, inst} FIFO feeding decode, with back-pressure, branch flush and halt drain.
module inst_fetch_queue #(
  parameter int A      = 4,
  parameter int W      = 9,
  parameter int QDEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  inst_fetch_queue_if.slave  bus
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH = CW'(QDEPTH);

  logic [W-1:0] mem [2**A];

  logic [A-1:0]  f1_pc_q;
  logic [W-1:0]  f1_inst_q;
  logic          f1_v_q, f1_v_d;

  logic [A-1:0]  q_pc_q   [QDEPTH];
  logic [W-1:0]  q_inst_q [QDEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          halt_q, halt_d;

  logic          capture;
  logic          push;
  logic          pop;
  logic [CW-1:0] occupancy;

  // Stall looks only at registered state; a pop in flight this cycle is ignored on purpose,
  // which keeps count + f1_v <= QDEPTH without a combinational path from id_ready.
  assign occupancy       = count_q + CW'(f1_v_q);
  assign bus.fetch_stall = (occupancy >= DEPTH);
  assign bus.valid_out   = (count_q != '0);
  assign bus.inst_out    = q_inst_q[rptr_q];
  assign bus.pc_out      = q_pc_q[rptr_q];
  assign bus.halt_out    = halt_q;

  assign capture = !bus.halt_in && !bus.fetch_stall && !bus.flush;
  assign push    = f1_v_q && !bus.flush;
  assign pop     = bus.valid_out && bus.id_ready && !bus.flush;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves one unassigned
    // and no latch is inferred.
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    f1_v_d  = capture;
    halt_d  = bus.halt_in && (count_q == '0) && !f1_v_q;

    if (bus.flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push) wptr_d = wptr_q + PW'(1);
      if (pop)  rptr_d = rptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: the instruction array has no reset; program contents must survive a reset, and
  // leaving it out of the reset network lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (bus.prog_we) mem[bus.prog_addr] <= bus.prog_data;
  end

  // NOTE: sequential state uses non-blocking assignments only, which is also what makes a
  // same-edge read of mem[] return the pre-write data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      f1_pc_q   <= '0;
      f1_inst_q <= '0;
      f1_v_q    <= 1'b0;
    end else begin
      f1_v_q <= f1_v_d;
      if (capture) begin
        f1_pc_q   <= bus.inst_addr_in;
        f1_inst_q <= mem[bus.inst_addr_in];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < QDEPTH; i++) begin
        q_pc_q[i]   <= '0;
        q_inst_q[i] <= '0;
      end
    end else if (push) begin
      q_pc_q[wptr_q]   <= f1_pc_q;
      q_inst_q[wptr_q] <= f1_inst_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      halt_q  <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      halt_q  <= halt_d;
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Scoreboard bench for inst_fetch_queue: stimulus pushes expected {pc, inst} pairs at capture,
// a monitor pops and compares on every dequeue; directed checks cover stall, flush, halt, reset.
module tb_inst_fetch_queue;

  localparam int A  = 4;
  localparam int W  = 9;
  localparam int QD = 4;

  typedef struct packed {
    logic [A-1:0] pc;
    logic [W-1:0] inst;
  } entry_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  inst_fetch_queue_if #(.A(A), .W(W)) bus ();

  inst_fetch_queue #(.A(A), .W(W), .QDEPTH(QD)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus.slave)
  );

  int           compared   = 0;
  int           mismatched = 0;
  entry_t       exp_q[$];
  logic [W-1:0] mem_m [2**A];

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: a dequeue happens on the coming edge whenever valid && ready && !flush.
  initial begin
    entry_t e;
    forever begin
      @(negedge clk);
      if (bus.valid_out && bus.id_ready && !bus.flush) begin
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_pop: got pc=0x%0h inst=0x%0h, expected no entry (t=%0t)",
                   bus.pc_out, bus.inst_out, $time);
        end else begin
          e = exp_q.pop_front();
          check("head_pc", int'(bus.pc_out), int'(e.pc));
          check("head_inst", int'(bus.inst_out), int'(e.inst));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Cycle helpers: drive at posedge+1, return at the negedge for sampling.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.halt_in = 1'b1;
    @(negedge clk);
  endtask

  task automatic fetch(input logic [A-1:0] a, output bit cap);
    bus.halt_in      = 1'b0;
    bus.inst_addr_in = a;
    @(negedge clk);
    cap = !bus.fetch_stall && !bus.flush;
    if (cap) exp_q.push_back('{pc: a, inst: mem_m[a]});
  endtask

  task automatic drain();
    bus.id_ready = 1'b1;
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
      idle();
      next_cycle();
    end
    check("drain_remaining", exp_q.size(), 0);
    for (int i = 0; i < 3; i++) begin
      idle();
      next_cycle();
    end
  endtask

  initial begin
    bit cap;

    rst_n            = 1'b1;
    bus.inst_addr_in = '0;
    bus.halt_in      = 1'b1;
    bus.prog_we      = 1'b0;
    bus.prog_addr    = '0;
    bus.prog_data    = '0;
    bus.flush        = 1'b0;
    bus.id_ready     = 1'b0;

    #2 rst_n = 1'b0;
    #1;
    check("rst_inst_out", int'(bus.inst_out), 0);
    check("rst_pc_out", int'(bus.pc_out), 0);
    check("rst_valid_out", int'(bus.valid_out), 0);
    check("rst_fetch_stall", int'(bus.fetch_stall), 0);
    check("rst_halt_out", int'(bus.halt_out), 0);

    // Program load while held in reset.
    for (int i = 0; i < 2**A; i++) begin
      @(posedge clk);
      #1;
      bus.prog_we   = 1'b1;
      bus.prog_addr = A'(i);
      bus.prog_data = W'(9'h100 + i);
      mem_m[i]      = W'(9'h100 + i);
    end
    @(posedge clk);
    #1;
    bus.prog_we = 1'b0;
    rst_n       = 1'b1;
    next_cycle();

    // Basic latency: address 0 at cycle N shows valid from cycle N+2.
    bus.id_ready = 1'b1;
    fetch(4'd0, cap);
    check("t1_valid_n0", int'(bus.valid_out), 0);
    next_cycle();
    fetch(4'd1, cap);
    check("t1_valid_n1", int'(bus.valid_out), 0);
    next_cycle();
    fetch(4'd2, cap);
    check("t1_valid_n2", int'(bus.valid_out), 1);
    check("t1_pc_n2", int'(bus.pc_out), 0);
    next_cycle();
    drain();

    // Back-pressure: decode stalled, stall once count + f1_v reaches QDEPTH.
    bus.id_ready = 1'b0;
    for (int a = 0; a < 4; a++) begin
      fetch(A'(a), cap);
      check("t2_stall_fill", int'(bus.fetch_stall), 0);
      next_cycle();
    end
    fetch(4'd4, cap);
    check("t2_stall_full_a", int'(bus.fetch_stall), 1);
    next_cycle();
    fetch(4'd4, cap);
    check("t2_stall_full_b", int'(bus.fetch_stall), 1);
    check("t2_head_pc", int'(bus.pc_out), 0);
    next_cycle();
    bus.id_ready = 1'b1;
    for (int a = 4; a < 8; a++) begin
      int tries = 0;
      do begin
        fetch(A'(a), cap);
        next_cycle();
        tries++;
      end while (!cap && tries < 20);
      check("t2_capture", int'(cap), 1);
    end
    drain();

    // Flush with 3 queued entries and F1 occupied.
    bus.id_ready = 1'b0;
    for (int a = 12; a < 16; a++) begin
      fetch(A'(a), cap);
      next_cycle();
    end
    bus.halt_in = 1'b1;
    bus.flush   = 1'b1;
    @(negedge clk);
    check("t3_stall_preflush", int'(bus.fetch_stall), 1);
    check("t3_valid_preflush", int'(bus.valid_out), 1);
    exp_q.delete();
    next_cycle();
    bus.flush    = 1'b0;
    bus.id_ready = 1'b1;
    fetch(4'd9, cap);
    check("t3_valid_postflush", int'(bus.valid_out), 0);
    check("t3_stall_postflush", int'(bus.fetch_stall), 0);
    next_cycle();
    idle();
    check("t3_valid_n1", int'(bus.valid_out), 0);
    next_cycle();
    idle();
    check("t3_valid_n2", int'(bus.valid_out), 1);
    next_cycle();
    drain();

    // Halt: two entries queued, halt_out only after the last pop.
    bus.id_ready = 1'b0;
    fetch(4'd2, cap);
    next_cycle();
    fetch(4'd6, cap);
    next_cycle();
    idle();
    next_cycle();
    bus.id_ready = 1'b1;
    idle();
    check("t4_halt_c0", int'(bus.halt_out), 0);
    next_cycle();
    idle();
    check("t4_halt_c1", int'(bus.halt_out), 0);
    next_cycle();
    idle();
    check("t4_halt_c2", int'(bus.halt_out), 0);
    next_cycle();
    idle();
    check("t4_halt_c3", int'(bus.halt_out), 1);
    next_cycle();
    fetch(4'd1, cap);
    check("t4_halt_hold", int'(bus.halt_out), 1);
    next_cycle();
    idle();
    check("t4_halt_drop", int'(bus.halt_out), 0);
    next_cycle();
    drain();

    // Asynchronous reset with a full queue, then memory contents preserved.
    bus.id_ready = 1'b0;
    for (int a = 4; a < 8; a++) begin
      fetch(A'(a), cap);
      next_cycle();
    end
    idle();
    next_cycle();
    idle();
    check("t5_stall_full", int'(bus.fetch_stall), 1);
    check("t5_head_pc", int'(bus.pc_out), 4);
    next_cycle();
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_inst_out", int'(bus.inst_out), 0);
    check("t5_rst_pc_out", int'(bus.pc_out), 0);
    check("t5_rst_valid_out", int'(bus.valid_out), 0);
    check("t5_rst_fetch_stall", int'(bus.fetch_stall), 0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n        = 1'b1;
    bus.id_ready = 1'b1;
    fetch(4'd5, cap);
    next_cycle();
    drain();

    // Read-during-write returns old data; next read sees the new word.
    bus.id_ready  = 1'b1;
    bus.prog_we   = 1'b1;
    bus.prog_addr = 4'd3;
    bus.prog_data = 9'h1FF;
    fetch(4'd3, cap);
    mem_m[3] = 9'h1FF;
    next_cycle();
    bus.prog_we = 1'b0;
    fetch(4'd3, cap);
    next_cycle();
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
